// File: rtl/ahb_pkg.sv
// rtl/ahb_pkg.sv - shared AHB-Lite transfer, response and default-slave state types
package ahb_pkg;

    typedef enum logic [1:0] {
        TRANS_IDLE   = 2'd0,
        TRANS_BUSY   = 2'd1,
        TRANS_NONSEQ = 2'd2,
        TRANS_SEQ    = 2'd3
    } htrans_e;

    localparam logic OKAY  = 1'b0;
    localparam logic ERROR = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ERR1 = 2'd1,
        ST_ERR2 = 2'd2
    } def_state_e;

endpackage

// File: rtl/ahb_default_slv.sv
// rtl/ahb_default_slv.sv - built-in default slave: two-cycle ERROR FSM, error counter, last error address
module ahb_default_slv
    import ahb_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  hclk,
    input  logic                  hresetn,
    input  logic                  def_acc,
    input  logic [ADDR_WIDTH-1:0] haddr,
    input  logic                  err_clr,
    output logic                  def_hready,
    output logic                  def_hresp,
    output logic [CNT_WIDTH-1:0]  err_cnt,
    output logic [ADDR_WIDTH-1:0] err_addr
);

    def_state_e            state_q, state_d;
    logic                  hready_q, hready_d;
    logic                  hresp_q, hresp_d;
    logic [CNT_WIDTH-1:0]  err_cnt_q, err_cnt_d;
    logic [ADDR_WIDTH-1:0] err_addr_q, err_addr_d;
    logic                  err_inc;

    always_comb begin
        state_d  = state_q;
        hready_d = 1'b1;
        hresp_d  = OKAY;
        err_inc  = 1'b0;
        unique case (state_q)
            ST_IDLE, ST_ERR2: begin
                if (def_acc) begin
                    state_d  = ST_ERR1;
                    hready_d = 1'b0;
                    hresp_d  = ERROR;
                    err_inc  = 1'b1;
                end else begin
                    state_d  = ST_IDLE;
                end
            end
            ST_ERR1: begin
                state_d  = ST_ERR2;
                hready_d = 1'b1;
                hresp_d  = ERROR;
            end
            default: state_d = ST_IDLE;
        endcase

        // A clear in the same cycle as a new error leaves that error counted.
        err_cnt_d = err_cnt_q;
        if (err_clr) begin
            err_cnt_d = err_inc ? CNT_WIDTH'(1) : '0;
        end else if (err_inc && err_cnt_q != {CNT_WIDTH{1'b1}}) begin
            err_cnt_d = err_cnt_q + CNT_WIDTH'(1);
        end

        err_addr_d = def_acc ? haddr : err_addr_q;
    end

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            state_q    <= ST_IDLE;
            hready_q   <= 1'b1;
            hresp_q    <= OKAY;
            err_cnt_q  <= '0;
            err_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            hready_q   <= hready_d;
            hresp_q    <= hresp_d;
            err_cnt_q  <= err_cnt_d;
            err_addr_q <= err_addr_d;
        end
    end

    assign def_hready = hready_q;
    assign def_hresp  = hresp_q;
    assign err_cnt    = err_cnt_q;
    assign err_addr   = err_addr_q;

endmodule

// File: rtl/ahb_dec_ctrl.sv
// rtl/ahb_dec_ctrl.sv - AHB-Lite address decoder with data-phase mux select and default slave
module ahb_dec_ctrl
    import ahb_pkg::*;
#(
    parameter int                   ADDR_WIDTH = 32,
    parameter int                   HSLV_NUM   = 5,
    parameter int                   HSLV_LEN   = 32,
    parameter int                   SLOT_SHIFT = 27,
    parameter logic [HSLV_LEN-1:0]  SLV_EN     = 32'h0000_001F,
    parameter int                   DEF_IDX    = HSLV_LEN - 1,
    parameter int                   CNT_WIDTH  = 16
) (
    input  logic                  hclk,
    input  logic                  hresetn,
    input  logic [ADDR_WIDTH-1:0] haddr,
    input  logic [1:0]            htrans,
    input  logic                  hready,
    output logic [HSLV_LEN-1:0]   hsel_o,
    output logic [HSLV_NUM-1:0]   hsel_dp,
    output logic                  def_hready,
    output logic                  def_hresp,
    output logic                  def_hexokay,
    input  logic                  err_clr,
    output logic [CNT_WIDTH-1:0]  err_cnt,
    output logic [ADDR_WIDTH-1:0] err_addr
);

    localparam logic [HSLV_NUM-1:0] DEF_SLOT = HSLV_NUM'(DEF_IDX);

    logic [HSLV_NUM-1:0] slot;
    logic [HSLV_NUM-1:0] dec_idx;
    logic [HSLV_NUM-1:0] hsel_dp_q, hsel_dp_d;
    htrans_e             trans;
    logic                def_acc;

    always_comb begin
        slot    = haddr[SLOT_SHIFT +: HSLV_NUM];
        dec_idx = DEF_SLOT;
        if (SLV_EN[slot] && (slot != DEF_SLOT)) begin
            dec_idx = slot;
        end

        // The default slot has no address-phase select; it is reached only via hsel_dp.
        hsel_o = '0;
        if (dec_idx != DEF_SLOT) begin
            hsel_o[dec_idx] = 1'b1;
        end

        hsel_dp_d = hready ? dec_idx : hsel_dp_q;

        trans   = htrans_e'(htrans);
        def_acc = hready && (trans == TRANS_NONSEQ || trans == TRANS_SEQ)
                  && (dec_idx == DEF_SLOT);
    end

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            hsel_dp_q <= DEF_SLOT;
        end else begin
            hsel_dp_q <= hsel_dp_d;
        end
    end

    assign hsel_dp     = hsel_dp_q;
    assign def_hexokay = 1'b0;

    ahb_default_slv #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .CNT_WIDTH  (CNT_WIDTH)
    ) u_def (
        .hclk       (hclk),
        .hresetn    (hresetn),
        .def_acc    (def_acc),
        .haddr      (haddr),
        .err_clr    (err_clr),
        .def_hready (def_hready),
        .def_hresp  (def_hresp),
        .err_cnt    (err_cnt),
        .err_addr   (err_addr)
    );

endmodule

// File: tb/tb_ahb_dec_ctrl.sv
// tb/tb_ahb_dec_ctrl.sv - directed vector bench for ahb_dec_ctrl
module tb_ahb_dec_ctrl;

    logic        hclk;
    logic        hresetn;
    logic [31:0] haddr;
    logic [1:0]  htrans;
    logic        hready;
    logic [31:0] hsel_o;
    logic [4:0]  hsel_dp;
    logic        def_hready;
    logic        def_hresp;
    logic        def_hexokay;
    logic        err_clr;
    logic [15:0] err_cnt;
    logic [31:0] err_addr;

    int n_vec;
    int n_err;

    ahb_dec_ctrl dut (
        .hclk        (hclk),
        .hresetn     (hresetn),
        .haddr       (haddr),
        .htrans      (htrans),
        .hready      (hready),
        .hsel_o      (hsel_o),
        .hsel_dp     (hsel_dp),
        .def_hready  (def_hready),
        .def_hresp   (def_hresp),
        .def_hexokay (def_hexokay),
        .err_clr     (err_clr),
        .err_cnt     (err_cnt),
        .err_addr    (err_addr)
    );

    initial hclk = 1'b0;
    always #5 hclk = ~hclk;

    typedef struct {
        logic [31:0] haddr;
        logic [1:0]  htrans;
        logic        hready;
        logic        clr;
        logic [31:0] hsel;
        logic [4:0]  dp;
        logic        rdy;
        logic        resp;
        logic [15:0] cnt;
        logic [31:0] eaddr;
    } vec_t;

    vec_t vt[19];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [31:0] a, input logic [1:0] t, input logic r, input logic c);
        haddr   = a;
        htrans  = t;
        hready  = r;
        err_clr = c;
    endtask

    task automatic chk_regs(input string tag, input logic [4:0] dp, input logic rdy,
                            input logic resp, input logic [15:0] cnt, input logic [31:0] ea);
        chk({tag, ".hsel_dp"}, 32'(hsel_dp), 32'(dp));
        chk({tag, ".def_hready"}, 32'(def_hready), 32'(rdy));
        chk({tag, ".def_hresp"}, 32'(def_hresp), 32'(resp));
        chk({tag, ".err_cnt"}, 32'(err_cnt), 32'(cnt));
        chk({tag, ".err_addr"}, err_addr, ea);
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;

        //        haddr          tr    rdy   clr   hsel_o        dp     rdy   resp  cnt     err_addr
        vt[0]  = '{32'h1000_0000, 2'd2, 1'b1, 1'b0, 32'h0000_0004, 5'd2,  1'b1, 1'b0, 16'd0, 32'h0000_0000};
        vt[1]  = '{32'h4000_0000, 2'd0, 1'b0, 1'b0, 32'h0000_0000, 5'd2,  1'b1, 1'b0, 16'd0, 32'h0000_0000};
        vt[2]  = '{32'h4000_0000, 2'd0, 1'b0, 1'b0, 32'h0000_0000, 5'd2,  1'b1, 1'b0, 16'd0, 32'h0000_0000};
        vt[3]  = '{32'h4000_0000, 2'd0, 1'b0, 1'b0, 32'h0000_0000, 5'd2,  1'b1, 1'b0, 16'd0, 32'h0000_0000};
        vt[4]  = '{32'h4000_0000, 2'd2, 1'b1, 1'b0, 32'h0000_0000, 5'd31, 1'b0, 1'b1, 16'd1, 32'h4000_0000};
        vt[5]  = '{32'h0000_0000, 2'd0, 1'b0, 1'b0, 32'h0000_0001, 5'd31, 1'b1, 1'b1, 16'd1, 32'h4000_0000};
        vt[6]  = '{32'h0000_0000, 2'd0, 1'b1, 1'b0, 32'h0000_0001, 5'd0,  1'b1, 1'b0, 16'd1, 32'h4000_0000};
        vt[7]  = '{32'h4800_0000, 2'd2, 1'b1, 1'b0, 32'h0000_0000, 5'd31, 1'b0, 1'b1, 16'd2, 32'h4800_0000};
        vt[8]  = '{32'h4800_0000, 2'd3, 1'b0, 1'b0, 32'h0000_0000, 5'd31, 1'b1, 1'b1, 16'd2, 32'h4800_0000};
        vt[9]  = '{32'h5000_0000, 2'd3, 1'b1, 1'b0, 32'h0000_0000, 5'd31, 1'b0, 1'b1, 16'd3, 32'h5000_0000};
        vt[10] = '{32'h5000_0000, 2'd0, 1'b0, 1'b0, 32'h0000_0000, 5'd31, 1'b1, 1'b1, 16'd3, 32'h5000_0000};
        vt[11] = '{32'hF800_0000, 2'd0, 1'b1, 1'b0, 32'h0000_0000, 5'd31, 1'b1, 1'b0, 16'd3, 32'h5000_0000};
        vt[12] = '{32'hF800_0000, 2'd1, 1'b1, 1'b0, 32'h0000_0000, 5'd31, 1'b1, 1'b0, 16'd3, 32'h5000_0000};
        vt[13] = '{32'h2000_0000, 2'd2, 1'b1, 1'b0, 32'h0000_0010, 5'd4,  1'b1, 1'b0, 16'd3, 32'h5000_0000};
        vt[14] = '{32'h2800_0000, 2'd0, 1'b1, 1'b0, 32'h0000_0000, 5'd31, 1'b1, 1'b0, 16'd3, 32'h5000_0000};
        vt[15] = '{32'h0000_0000, 2'd0, 1'b1, 1'b1, 32'h0000_0001, 5'd0,  1'b1, 1'b0, 16'd0, 32'h5000_0000};
        vt[16] = '{32'h4000_0000, 2'd2, 1'b1, 1'b1, 32'h0000_0000, 5'd31, 1'b0, 1'b1, 16'd1, 32'h4000_0000};
        vt[17] = '{32'h0000_0000, 2'd0, 1'b0, 1'b0, 32'h0000_0001, 5'd31, 1'b1, 1'b1, 16'd1, 32'h4000_0000};
        vt[18] = '{32'h0000_0000, 2'd0, 1'b1, 1'b0, 32'h0000_0001, 5'd0,  1'b1, 1'b0, 16'd1, 32'h4000_0000};

        // Reset state
        hresetn = 1'b0;
        drive(32'hF800_0000, 2'd0, 1'b1, 1'b0);
        repeat (3) @(posedge hclk);
        @(negedge hclk);
        hresetn = 1'b1;
        #1;
        chk("rst.hsel_o", hsel_o, 32'h0);
        chk("rst.def_hexokay", 32'(def_hexokay), 32'h0);
        chk_regs("rst", 5'd31, 1'b1, 1'b0, 16'd0, 32'h0);

        // Table vectors: inputs set at negedge, decode checked before the edge, registers after it
        for (int i = 0; i < 19; i++) begin
            @(negedge hclk);
            drive(vt[i].haddr, vt[i].htrans, vt[i].hready, vt[i].clr);
            #1;
            chk($sformatf("v%0d.hsel_o", i), hsel_o, vt[i].hsel);
            @(posedge hclk);
            #1;
            chk_regs($sformatf("v%0d", i), vt[i].dp, vt[i].rdy, vt[i].resp, vt[i].cnt, vt[i].eaddr);
        end

        // Counter saturation
        @(negedge hclk);
        force dut.u_def.err_cnt_q = 16'hFFFF;
        #1;
        release dut.u_def.err_cnt_q;
        drive(32'h4000_0000, 2'd2, 1'b1, 1'b0);
        @(posedge hclk);
        #1;
        chk_regs("sat", 5'd31, 1'b0, 1'b1, 16'hFFFF, 32'h4000_0000);
        @(negedge hclk);
        drive(32'h0, 2'd0, 1'b0, 1'b0);
        @(posedge hclk);
        #1;
        chk_regs("sat.err2", 5'd31, 1'b1, 1'b1, 16'hFFFF, 32'h4000_0000);

        // Asynchronous reset in the middle of ERR1
        @(negedge hclk);
        drive(32'h6000_0000, 2'd2, 1'b1, 1'b0);
        @(posedge hclk);
        #1;
        chk_regs("arst.err1", 5'd31, 1'b0, 1'b1, 16'hFFFF, 32'h6000_0000);
        #1;
        hresetn = 1'b0;
        #1;
        chk_regs("arst.now", 5'd31, 1'b1, 1'b0, 16'd0, 32'h0);
        @(negedge hclk);
        drive(32'h0, 2'd0, 1'b1, 1'b0);
        hresetn = 1'b1;
        @(posedge hclk);
        #1;
        chk_regs("arst.after", 5'd0, 1'b1, 1'b0, 16'd0, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: bench did not finish, expected completion");
        $fatal(1);
    end

endmodule

// File: doc/ahb_dec_ctrl.md
Name: ahb_dec_ctrl

Overview:
- AHB-Lite address decoder and data-phase select controller for the slave-to-master response mux.
- Decodes haddr into one-hot address-phase slave selects.
- Registers the selected slot index on each accepted transfer and drives it as the mux select during the data phase.
- Implements the built-in default slave: two-cycle ERROR for unmapped or disabled slots, plus an error counter and last-error-address capture.

Parameters:
- ADDR_WIDTH, 32, haddr width.
- HSLV_NUM, 5, width of the slot index driven to the response mux.
- HSLV_LEN, 32, number of slave slots; must equal 2**HSLV_NUM.
- SLOT_SHIFT, 27, LSB of the slot field; slot = haddr[SLOT_SHIFT+HSLV_NUM-1:SLOT_SHIFT].
- SLV_EN, 32'h0000_001F, per-slot enable mask; bit i=0 maps slot i to the default slave.
- DEF_IDX, HSLV_LEN-1, slot index reserved for the default slave; its SLV_EN bit is ignored.
- CNT_WIDTH, 16, error counter width.

Ports:
- hclk  input  1  AHB clock.
- hresetn  input  1  asynchronous active-low reset.
- haddr  input  ADDR_WIDTH  address-phase address.
- htrans  input  2  address-phase transfer type (IDLE=0, BUSY=1, NONSEQ=2, SEQ=3).
- hready  input  1  bus HREADY, i.e. the mux hready_o fed back.
- hsel_o  output  HSLV_LEN  one-hot address-phase slave select; bit DEF_IDX is unused and driven 0.
- hsel_dp  output  HSLV_NUM  data-phase slot index to the response mux select.
- def_hready  output  1  default slave HREADYOUT; feeds mux slot DEF_IDX.
- def_hresp  output  1  default slave HRESP; feeds mux slot DEF_IDX.
- def_hexokay  output  1  default slave HEXOKAY; constant 0.
- err_clr  input  1  synchronous clear of err_cnt.
- err_cnt  output  CNT_WIDTH  saturating count of ERROR responses issued.
- err_addr  output  ADDR_WIDTH  haddr of the most recent default-slave transfer.

Behaviour:
- Reset values:
  - hsel_dp = DEF_IDX.
  - def_hready = 1, def_hresp = 0, def_hexokay = 0.
  - err_cnt = 0, err_addr = 0.
  - FSM in IDLE.
- Decode (combinational):
  - dec_idx = slot field of haddr if SLV_EN[slot]=1 and slot != DEF_IDX; otherwise dec_idx = DEF_IDX.
  - hsel_o = one-hot of dec_idx; all zeros when dec_idx = DEF_IDX.
  - hsel_o does not depend on htrans.
- Data-phase select:
  - On a rising hclk edge with hready=1: hsel_dp <= dec_idx.
  - With hready=0: hsel_dp holds.
  - One-cycle latency from the address phase.
  - hsel_dp changes only on hready=1 edges.
- Transfer qualifier: def_acc = hready & htrans[1] & (dec_idx == DEF_IDX).
- Default-slave FSM states: IDLE, ERR1, ERR2.
  - IDLE:
    - Outputs def_hready=1, def_hresp=0.
    - def_acc → ERR1; otherwise stay in IDLE.
    - IDLE/BUSY transfers to the default slave get a zero-wait OKAY.
  - ERR1: outputs def_hready=0, def_hresp=1; unconditionally → ERR2.
  - ERR2:
    - Outputs def_hready=1, def_hresp=1.
    - def_acc → ERR1, for a back-to-back error.
    - Otherwise → IDLE.
    - A master cancelling with htrans=IDLE in ERR2 returns the FSM to IDLE.
  - All three outputs come straight from flops; there are no combinational paths from inputs.
- Error capture:
  - On def_acc: err_addr <= haddr.
  - On the IDLE→ERR1 or ERR2→ERR1 transition: err_cnt increments and saturates at all-ones.
- err_clr and an increment in the same cycle: err_cnt <= 1. An increment alone at saturation holds.
- An asynchronous reset mid-ERR1/ERR2 returns everything to reset values immediately; no partial response is completed.
- BUSY/SEQ to an unmapped slot is treated by htrans[1] alone; SEQ errors like NONSEQ.

Decomposition:
- Shared package ahb_pkg:
  - htrans_e enum (IDLE, BUSY, NONSEQ, SEQ).
  - hresp constants OKAY=0, ERROR=1.
  - def_state_e enum (IDLE, ERR1, ERR2).
- One natural sub-module, ahb_default_slv: FSM plus err_cnt/err_addr.
- The top keeps the decode and the hsel_dp register.

Test Plan:
- Reset: deassert hresetn → hsel_dp=31, def_hready=1, def_hresp=0, err_cnt=0, hsel_o=0 for haddr=0xF800_0000.
- Mapped NONSEQ, haddr=0x1000_0000 (slot 2), hready=1:
  - hsel_o=32'h4 the same cycle.
  - hsel_dp=2 the next cycle.
  - With hready held 0 for 3 cycles, hsel_dp stays 2.
- Unmapped NONSEQ, haddr=0x4000_0000 (slot 8, disabled):
  - Cycle+1: def_hready=0, def_hresp=1.
  - Cycle+2: def_hready=1, def_hresp=1.
  - Then IDLE; err_cnt=1, err_addr=0x4000_0000, hsel_dp=31.
- Back-to-back: second unmapped NONSEQ presented in ERR2 → ERR1 again directly, err_cnt=2. IDLE presented in ERR2 → IDLE, OKAY.
- IDLE/BUSY htrans to the default slot → def_hready=1, def_hresp=0, err_cnt unchanged.
- Counter edges:
  - Force err_cnt=16'hFFFF; another error → stays 16'hFFFF.
  - err_clr coincident with an ERR1 entry → err_cnt=1.
  - hresetn pulsed low during ERR1 → def_hready=1, def_hresp=0 asynchronously.
